risc_imm_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Each cycle it accepts one instruction word, a 3-bit format select and a side-band tag. It returns the sign- or zero-extended XLEN-wide immediate one cycle later through a valid/ready handshake with a 2-entry skid buffer. It sits between fetch/decode and the ID/EX register and supports pipeline flush for branch/hazard recovery.

---
 rtl/risc_pkg.sv | 21 ++
 rtl/risc_imm_dec.sv | 64 ++++++
 rtl/risc_imm_pipe.sv | 129 ++++++++++++
 tb/tb_risc_imm_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared decode package.
// Holds the immediate format select encoding and the default widths used by
// the immediate generator and the other decode paths.
package risc_pkg;

    // Format select carried with each instruction into the immediate generator.
    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_J   = 3'b011,
        FMT_U   = 3'b100,
        FMT_SH  = 3'b101,
        FMT_Z   = 3'b110,
        FMT_ILL = 3'b111
    } imm_fmt_e;

    localparam int XLEN_DEFAULT  = 32;
    localparam int TAG_W_DEFAULT = 8;

endpackage

// File: rtl/risc_imm_dec.sv
// Combinational immediate decoder.
// Maps a raw 32-bit instruction word and a format select to an XLEN-wide
// extended immediate. An unknown format (3'b111) decodes as I-format and
// raises illegal.
// Ports:
//   inst    in  32    raw instruction word
//   fmt     in  3     format select (imm_fmt_e encoding)
//   imm     out XLEN  extended immediate
//   illegal out 1     fmt was 3'b111
module risc_imm_dec
    import risc_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Bit 5 of the shift amount only exists on 64-bit datapaths.
    logic shamt_hi;

    generate
        if (XLEN == 64) begin : g_shamt64
            assign shamt_hi = inst[25];
        end else begin : g_shamt32
            assign shamt_hi = 1'b0;
        end
    endgenerate

    // Every format is first formed as a 32-bit value whose bit 31 is the
    // correct extension bit (inst[31] for signed formats, 0 for the
    // zero-extended ones), so widening to XLEN is a single replication.
    logic [31:0] imm32;

    always_comb begin
        imm32 = {{20{inst[31]}}, inst[31:20]};
        unique case (imm_fmt_e'(fmt))
            FMT_I, FMT_ILL: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:          imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:          imm32 = {{19{inst[31]}}, inst[31], inst[7],
                                     inst[30:25], inst[11:8], 1'b0};
            FMT_J:          imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                                     inst[20], inst[30:21], 1'b0};
            FMT_U:          imm32 = {inst[31:12], 12'b0};
            FMT_SH:         imm32 = {26'b0, shamt_hi, inst[24:20]};
            FMT_Z:          imm32 = {27'b0, inst[19:15]};
            default:        imm32 = {{20{inst[31]}}, inst[31:20]};
        endcase
    end

    always_comb begin
        imm        = {XLEN{imm32[31]}};
        imm[31:0]  = imm32;
    end

    assign illegal = (fmt == FMT_ILL);

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

endmodule

// File: rtl/risc_imm_pipe.sv
// Pipelined immediate generator for the decode stage.
// Decodes the incoming instruction combinationally, then holds the result in
// a 2-entry FIFO (main + skid) behind a valid/ready handshake. in_ready is
// pure registered state so there is no combinational path from out_ready.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop buffered entries and the same-cycle input
//   in_valid/in_ready   input handshake
//   in_inst/fmt/tag     instruction word, format select, side-band tag
//   out_valid/out_ready output handshake
//   out_imm/tag/illegal extended immediate, tag, illegal-format flag
module risc_imm_pipe
    import risc_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    risc_imm_dec #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .fmt     (in_fmt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    logic             main_valid_reg, main_valid_next;
    logic [XLEN-1:0]  main_imm_reg,   main_imm_next;
    logic [TAG_W-1:0] main_tag_reg,   main_tag_next;
    logic             main_ill_reg,   main_ill_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [XLEN-1:0]  skid_imm_reg,   skid_imm_next;
    logic [TAG_W-1:0] skid_tag_reg,   skid_tag_next;
    logic             skid_ill_reg,   skid_ill_next;

    logic push;
    logic pop;

    assign in_ready = !skid_valid_reg;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = main_valid_reg && out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_imm_next   = main_imm_reg;
        main_tag_next   = main_tag_reg;
        main_ill_next   = main_ill_reg;
        skid_valid_next = skid_valid_reg;
        skid_imm_next   = skid_imm_reg;
        skid_tag_next   = skid_tag_reg;
        skid_ill_next   = skid_ill_reg;

        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (pop) begin
            if (skid_valid_reg) begin
                // push cannot happen here: in_ready is low while skid is full
                main_imm_next   = skid_imm_reg;
                main_tag_next   = skid_tag_reg;
                main_ill_next   = skid_ill_reg;
                skid_valid_next = 1'b0;
            end else if (push) begin
                // replace the departing entry in place: no bubble
                main_imm_next   = dec_imm;
                main_tag_next   = in_tag;
                main_ill_next   = dec_illegal;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (push) begin
            if (main_valid_reg) begin
                skid_valid_next = 1'b1;
                skid_imm_next   = dec_imm;
                skid_tag_next   = in_tag;
                skid_ill_next   = dec_illegal;
            end else begin
                main_valid_next = 1'b1;
                main_imm_next   = dec_imm;
                main_tag_next   = in_tag;
                main_ill_next   = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_imm_reg   <= '0;
            main_tag_reg   <= '0;
            main_ill_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_imm_reg   <= '0;
            skid_tag_reg   <= '0;
            skid_ill_reg   <= 1'b0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_imm_reg   <= main_imm_next;
            main_tag_reg   <= main_tag_next;
            main_ill_reg   <= main_ill_next;
            skid_valid_reg <= skid_valid_next;
            skid_imm_reg   <= skid_imm_next;
            skid_tag_reg   <= skid_tag_next;
            skid_ill_reg   <= skid_ill_next;
        end
    end

    assign out_valid   = main_valid_reg;
    assign out_imm     = main_imm_reg;
    assign out_tag     = main_tag_reg;
    assign out_illegal = main_ill_reg;

endmodule

// File: tb/tb_risc_imm_pipe.sv
// Bench for risc_imm_pipe: a 32-bit and a 64-bit instance share one stimulus
// stream. A queue-based reference model predicts handshake state and contents;
// immediates are predicted with plain shift/mask arithmetic.
module tb_risc_imm_pipe;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [2:0]       in_fmt;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready32, out_valid32, out_illegal32;
    logic [31:0]      out_imm32;
    logic [TAG_W-1:0] out_tag32;
    logic             in_ready64, out_valid64, out_illegal64;
    logic [63:0]      out_imm64;
    logic [TAG_W-1:0] out_tag64;

    always #5 clk = ~clk;

    risc_imm_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
    );

    risc_imm_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]      inst;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           model_q[$];
    logic [TAG_W-1:0] popped[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Immediate built from field arithmetic on the instruction word.
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] fmt,
                                            input bit x64);
        longint      sx;
        logic [63:0] u;
        logic [63:0] r;
        sx = longint'(signed'(inst));
        u  = {32'b0, inst};
        case (fmt)
            3'd1: r = 64'((sx >>> 25) << 5) | ((u >> 7) & 64'h1f);
            3'd2: r = 64'((sx >>> 31) << 12) | (((u >> 7) & 64'h1) << 11)
                    | (((u >> 25) & 64'h3f) << 5) | (((u >> 8) & 64'hf) << 1);
            3'd3: r = 64'((sx >>> 31) << 20) | (((u >> 12) & 64'hff) << 12)
                    | (((u >> 20) & 64'h1) << 11) | (((u >> 21) & 64'h3ff) << 1);
            3'd4: r = 64'((sx >>> 12) << 12);
            3'd5: r = (u >> 20) & (x64 ? 64'h3f : 64'h1f);
            3'd6: r = (u >> 15) & 64'h1f;
            default: r = 64'(sx >>> 20);
        endcase
        if (!x64) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    // One clock cycle. Called at posedge+1; drives inputs, checks the
    // current outputs against the model, advances through the edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [2:0] fmt,
                        input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
        bit     exp_valid, exp_ready, do_pop, do_push;
        entry_t e;
        in_valid  = v;
        in_inst   = inst;
        in_fmt    = fmt;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_valid = (model_q.size() > 0);
        exp_ready = (model_q.size() < 2);
        chk("out_valid32", 64'(out_valid32), 64'(exp_valid));
        chk("out_valid64", 64'(out_valid64), 64'(exp_valid));
        chk("in_ready32",  64'(in_ready32),  64'(exp_ready));
        chk("in_ready64",  64'(in_ready64),  64'(exp_ready));
        if (exp_valid) begin
            e = model_q[0];
            chk("out_imm32", 64'(out_imm32), ref_imm(e.inst, e.fmt, 1'b0));
            chk("out_imm64", out_imm64, ref_imm(e.inst, e.fmt, 1'b1));
            chk("out_tag32", 64'(out_tag32), 64'(e.tag));
            chk("out_tag64", 64'(out_tag64), 64'(e.tag));
            chk("out_illegal32", 64'(out_illegal32), 64'(e.fmt == 3'b111));
            chk("out_illegal64", 64'(out_illegal64), 64'(e.fmt == 3'b111));
        end
        do_pop  = exp_valid && ordy;
        do_push = v && exp_ready && !fl;
        if (do_pop) begin
            popped.push_back(out_tag32);
            $display("pop tag=%0d imm32=%h imm64=%h ill=%0b", out_tag32, out_imm32,
                     out_imm64, out_illegal32);
        end
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.inst = inst; e.fmt = fmt; e.tag = tag;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        ill;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1] = '{32'hFE20AE23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[2] = '{32'h00000863, 3'b010, 32'h00000010, 64'h0000000000000010, 1'b0};
        vecs[3] = '{32'h800000EF, 3'b011, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[4] = '{32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[5] = '{32'h80000037, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[6] = '{32'h03F01093, 3'b101, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[7] = '{32'h000FD073, 3'b110, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[8] = '{32'hFFF00093, 3'b111, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_fmt = '0;
        in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid32), 64'd0);
        chk("reset_in_ready",  64'(in_ready32),  64'd1);
        chk("reset_out_imm32", 64'(out_imm32),   64'd0);
        chk("reset_out_imm64", out_imm64,        64'd0);
        chk("reset_out_tag",   64'(out_tag64),   64'd0);
        chk("reset_out_ill",   64'(out_illegal64), 64'd0);
        rst = 1'b0;

        // Format table, one per cycle with out_ready high.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vecs[i].inst, vecs[i].fmt, TAG_W'(i + 40), 1'b1, 1'b0);
            chk("tbl_valid", 64'(out_valid32), 64'd1);
            chk("tbl_imm32", 64'(out_imm32), 64'(vecs[i].exp32));
            chk("tbl_imm64", out_imm64, vecs[i].exp64);
            chk("tbl_ill",   64'(out_illegal64), 64'(vecs[i].ill));
            chk("tbl_tag",   64'(out_tag32), 64'(i + 40));
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        popped.delete();

        // Backpressure: tags 1,2,3 offered with out_ready low.
        step(1'b1, 32'h00100093, 3'b000, 8'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 3'b000, 8'd2, 1'b0, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
        step(1'b1, 32'h00300093, 3'b000, 8'd3, 1'b0, 1'b0);
        step(1'b1, 32'h00300093, 3'b000, 8'd3, 1'b0, 1'b0);
        step(1'b1, 32'h00300093, 3'b000, 8'd3, 1'b1, 1'b0);
        step(1'b1, 32'h00300093, 3'b000, 8'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("bp_pop_count", 64'(popped.size()), 64'd3);
        for (int i = 0; i < 3 && i < popped.size(); i++)
            chk("bp_pop_order", 64'(popped[i]), 64'(i + 1));
        popped.delete();

        // Flush with two buffered entries plus a live input.
        step(1'b1, 32'h00A00093, 3'b000, 8'd10, 1'b0, 1'b0);
        step(1'b1, 32'h00B00093, 3'b000, 8'd11, 1'b0, 1'b0);
        step(1'b1, 32'h00C00093, 3'b000, 8'd12, 1'b1, 1'b1);
        chk("flush_out_valid", 64'(out_valid32), 64'd0);
        chk("flush_in_ready",  64'(in_ready64),  64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("flush_one_pop", 64'(popped.size()), 64'd1);
        popped.delete();

        // Asynchronous reset with two entries buffered.
        step(1'b1, 32'hFFF00093, 3'b000, 8'd20, 1'b0, 1'b0);
        step(1'b1, 32'hFFF00093, 3'b000, 8'd21, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("arst_out_valid", 64'(out_valid32), 64'd0);
        chk("arst_out_imm32", 64'(out_imm32),   64'd0);
        chk("arst_out_imm64", out_imm64,        64'd0);
        chk("arst_in_ready",  64'(in_ready32),  64'd1);
        model_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 32'h123450B7, 3'b100, 8'd22, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Randomised traffic against the queue model.
        for (int c = 0; c < 10000; c++) begin
            step(($urandom_range(0, 9) < 7), $urandom(), 3'($urandom_range(0, 7)),
                 TAG_W'(c), ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
